win_scan: RTL
=============

WIN_SCAN -- requirements
Module: win_scan

Interface
REQ-001 SHALL have parameter N, default 3, board side length; legal range 3..8.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request to scan the board presented on ain/bin.
REQ-005 SHALL have port ain  input  N*N  player-A occupancy; cell (r,c) is bit r*N+c (row-major, bit 0 top-left).
REQ-006 SHALL have port bin  input  N*N  player-B occupancy, same mapping.
REQ-007 SHALL have port busy  output  1  high while a scan is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-009 SHALL have port win_line  output  2N+2  completed lines: bits 0..N-1 are rows (top to bottom), N..2N-1 are columns (left to right), 2N is the main diagonal (cells 0, N+1, 2N+2, ...), 2N+1 is the anti-diagonal (cells N-1, 2N-2, ...).
REQ-010 SHALL have port a_wins  output  1  at least one line fully owned by A.
REQ-011 SHALL have port b_wins  output  1  at least one line fully owned by B.
REQ-012 SHALL have port draw  output  1  board full (ain|bin all ones), no winner.
REQ-013 SHALL have port illegal  output  1  some cell is set in both ain and bin.

Function
REQ-014 SHALL implement FSM states IDLE, CHECK, SCAN, DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, register ain/bin, clear all result outputs, and enter CHECK; ain/bin are not sampled at any other time.
REQ-016 SHALL ignore start in CHECK and SCAN.
REQ-017 SHALL, in CHECK, enter DONE with illegal=1 and win_line, a_wins, b_wins, draw all 0 if (ain & bin) != 0; otherwise enter SCAN with line counter 0.
REQ-018 SHALL, in SCAN, evaluate exactly one line per cycle, in win_line bit order 0..2N+1, using a counter of ceil(log2(2N+2)) bits.
REQ-019 SHALL set the win_line bit for a line if all N cells are set in ain, or all N cells are set in bin; the corresponding a_wins or b_wins is set in the same cycle.
REQ-020 SHALL report A and B wins simultaneously when both occur (both flags 1); no priority is applied.
REQ-021 SHALL leave SCAN for DONE after evaluating line 2N+1; draw is computed on DONE entry as (full board) AND NOT (a_wins OR b_wins).
REQ-022 SHALL assert done for exactly the DONE cycle; DONE returns to IDLE when start=0.
REQ-023 SHALL assert busy in CHECK and SCAN only.
REQ-024 SHALL have fixed latency: start sampled in cycle t gives done in cycle t+2N+4 (t+10 for N=3) for a legal board, and in cycle t+2 for an illegal board.
REQ-025 SHALL hold win_line, a_wins, b_wins, draw, and illegal stable from DONE until the next accepted start.
REQ-026 SHALL treat an empty board as legal: no wins, draw=0.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, enter IDLE, clear the line counter and stored boards, and drive busy, done, win_line, a_wins, b_wins, draw, and illegal to 0.
REQ-028 SHALL give rst priority over start in the same cycle, and abort any scan in progress with no done pulse.

Verification (N=3 unless stated)
REQ-029 SHALL cover: rst, then start with ain=0, bin=0 -> busy 1 for cycles t+1..t+9, done in cycle t+10, win_line=8'b00000000, all flags 0.
REQ-030 SHALL cover: ain=9'b000000111, bin=0 -> done in cycle t+10, win_line=8'b00000001, a_wins=1, b_wins=0.
REQ-031 SHALL cover: ain=0, bin=9'b100010001 -> win_line=8'b01000000, b_wins=1; then ain=9'b001010100, bin=0 -> win_line=8'b10000000, a_wins=1.
REQ-032 SHALL cover: ain=9'b000010000, bin=9'b000010001 -> done in cycle t+2, illegal=1, win_line=0; ain=9'b110001101, bin=9'b001110010 -> draw=1, win_line=0.
REQ-033 SHALL cover: start repeated during SCAN -> ignored, latency unchanged; rst asserted 3 cycles after start -> busy=0, no done pulse, all outputs 0.
REQ-034 SHALL cover: N=4, ain=16'h000F and bin=16'hF000 -> done in cycle t+12, win_line=10'b0000001001, a_wins=1, b_wins=1.

Source files
------------

// File: rtl/win_scan.sv
// Tic-tac-toe style N x N board scanner: checks one line per cycle for A/B
// completions, then reports wins, draw or an illegal (overlapping) board.
module win_scan #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N-1:0]   ain,
    input  logic [N*N-1:0]   bin,
    output logic             busy,
    output logic             done,
    output logic [2*N+1:0]   win_line,
    output logic             a_wins,
    output logic             b_wins,
    output logic             draw,
    output logic             illegal
);

    localparam int unsigned NN = N * N;
    localparam int unsigned NL = 2 * N + 2;
    localparam int unsigned CW = $clog2(NL);
    localparam logic [CW-1:0] LAST = CW'(NL - 1);

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NN-1:0]   a_q, a_d, b_q, b_d;
    logic [NL-1:0]   win_d;
    logic            busy_d, done_d, a_wins_d, b_wins_d, draw_d, illegal_d;
    logic [NN-1:0]   mask;
    logic            a_hit, b_hit;

    // Cell mask of line k, numbered in win_line bit order.
    function automatic logic [NN-1:0] line_mask(input logic [CW-1:0] k);
        logic [NN-1:0] m;
        int            li;
        m  = '0;
        li = 32'(k);
        for (int r = 0; r < N; r++) begin
            if (li < N)
                m |= NN'(1) << (li * N + r);
            else if (li < 2 * N)
                m |= NN'(1) << (r * N + li - N);
            else if (li == 2 * N)
                m |= NN'(1) << (r * N + r);
            else
                m |= NN'(1) << (r * N + N - 1 - r);
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            win_line <= '0;
            a_wins   <= 1'b0;
            b_wins   <= 1'b0;
            draw     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy     <= busy_d;
            done     <= done_d;
            win_line <= win_d;
            a_wins   <= a_wins_d;
            b_wins   <= b_wins_d;
            draw     <= draw_d;
            illegal  <= illegal_d;
        end
    end

    // Next-state and next-output logic; busy/done describe the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        win_d     = win_line;
        a_wins_d  = a_wins;
        b_wins_d  = b_wins;
        draw_d    = draw;
        illegal_d = illegal;
        mask      = line_mask(cnt_q);
        a_hit     = (a_q & mask) == mask;
        b_hit     = (b_q & mask) == mask;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d       = ain;
                    b_d       = bin;
                    win_d     = '0;
                    a_wins_d  = 1'b0;
                    b_wins_d  = 1'b0;
                    draw_d    = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = CHECK;
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if ((a_q & b_q) != '0) begin
                    illegal_d = 1'b1;
                    state_d   = DONE;
                    done_d    = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                win_d    = win_line | (NL'(a_hit | b_hit) << cnt_q);
                a_wins_d = a_wins | a_hit;
                b_wins_d = b_wins | b_hit;
                if (cnt_q == LAST) begin
                    draw_d  = (&(a_q | b_q)) & ~(a_wins_d | b_wins_d);
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
